mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        rw;
    logic        is_load_unsigned;
    logic [1:0]  byte_half_word;
    logic [31:0] addr;
    logic [31:0] data_in;
  } mem_req_t;

  localparam int PORT_CORE = 0;
  localparam int PORT_EEI  = 1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin pick; the requester not served last wins a tie.
module mem_arb_rr_pick
  import mem_port_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_served,
  output logic [1:0] winner,
  output logic       found
);

  always_comb begin
    winner = req_valid;
    if (&req_valid) begin
      winner = (last_served == 1'(PORT_EEI)) ? 2'b01 : 2'b10;
    end
  end

  assign found = |req_valid;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and EEI.
// Define MEM_PORT_ARB_TIMEOUT_EN to add the ACCESS watchdog (limit TIMEOUT_CYCLES).
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_rw,
  input  logic [1:0]       req_is_load_unsigned,
  input  logic [1:0][1:0]  req_byte_half_word,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_data_in,
  output logic [1:0]       resp_ready,
  output logic [1:0]       resp_out_of_range,
  output logic [1:0][31:0] resp_data_out,
  output logic [1:0]       grant,
  output logic             mem_valid,
  output logic             mem_rw,
  output logic             mem_is_load_unsigned,
  output logic [1:0]       mem_byte_half_word,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data_in,
  input  logic             mem_ready,
  input  logic             mem_out_of_range,
  input  logic [31:0]      mem_data_out,
  output logic             timeout_err
);

  // state     | meaning
  // ST_IDLE   | no owner; pick and latch a request when any req_valid is high
  // ST_ACCESS | memory port driven from latched request, wait for ready/out-of-range
  // ST_RESP   | one-cycle response pulse to the owner, then back to idle

  arb_state_e      state;
  logic            owner;
  logic            last_served;
  mem_req_t        req_lat;
  mem_req_t [1:0]  cand;
  logic [1:0]      win;
  logic            win_found;
  logic            win_idx;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cand[i].rw               = req_rw[i];
      cand[i].is_load_unsigned = req_is_load_unsigned[i];
      cand[i].byte_half_word   = req_byte_half_word[i];
      cand[i].addr             = req_addr[i];
      cand[i].data_in          = req_data_in[i];
    end
  end

  mem_arb_rr_pick u_pick (
    .req_valid  (req_valid),
    .last_served(last_served),
    .winner     (win),
    .found      (win_found)
  );

  assign win_idx = win[PORT_EEI];

  assign mem_rw               = req_lat.rw;
  assign mem_is_load_unsigned = req_lat.is_load_unsigned;
  assign mem_byte_half_word   = req_lat.byte_half_word;
  assign mem_addr             = req_lat.addr;
  assign mem_data_in          = req_lat.data_in;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      owner             <= 1'b0;
      last_served       <= 1'b1;
      req_lat           <= '0;
      grant             <= '0;
      mem_valid         <= 1'b0;
      resp_ready        <= '0;
      resp_out_of_range <= '0;
      resp_data_out     <= '0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      wdog_cnt          <= '0;
      timeout_err       <= 1'b0;
`endif
    end else begin
      resp_ready        <= '0;
      resp_out_of_range <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            owner     <= win_idx;
            req_lat   <= cand[win_idx];
            grant     <= win;
            mem_valid <= 1'b1;
            state     <= ST_ACCESS;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            wdog_cnt  <= '0;
`endif
          end
        end
        ST_ACCESS: begin
          if (mem_ready || mem_out_of_range) begin
            mem_valid                <= 1'b0;
            resp_ready[owner]        <= 1'b1;
            resp_out_of_range[owner] <= mem_out_of_range;
            resp_data_out[owner]     <= mem_data_out;
            state                    <= ST_RESP;
          end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          // Memory never answered: report out-of-range with zero data.
          else if (wdog_cnt == WDOG_LAST) begin
            mem_valid                <= 1'b0;
            resp_ready[owner]        <= 1'b1;
            resp_out_of_range[owner] <= 1'b1;
            resp_data_out[owner]     <= '0;
            timeout_err              <= 1'b1;
            state                    <= ST_RESP;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          grant       <= '0;
          last_served <= owner;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
